mult_div_unit: RTL

//   Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers.

---
 rtl/mdu_pkg.sv | 48 ++++
 rtl/mdu_arith.sv | 75 +++++++
 rtl/mult_div_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: opcode encodings,
// default latencies and opcode classification helpers.
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
package mdu_pkg;

  localparam int MDU_OP_W = 4;

  localparam logic [MDU_OP_W-1:0] MDU_OP_MULT  = 4'd0;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MULTU = 4'd1;
  localparam logic [MDU_OP_W-1:0] MDU_OP_DIV   = 4'd2;
  localparam logic [MDU_OP_W-1:0] MDU_OP_DIVU  = 4'd3;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MTHI  = 4'd4;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MTLO  = 4'd5;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MADD  = 4'd6;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MADDU = 4'd7;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MSUB  = 4'd8;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MSUBU = 4'd9;

  localparam int MDU_DEF_WIDTH       = 32;
  localparam int MDU_DEF_MULT_CYCLES = 5;
  localparam int MDU_DEF_DIV_CYCLES  = 10;

  // Control FSM: either waiting for a launch or counting down an operation.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_t;

  // True for opcodes that use the divider latency.
  function automatic logic mdu_is_div(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
  endfunction

  // True for opcodes that start a multi-cycle operation in this build.
  function automatic logic mdu_launchable(input logic [MDU_OP_W-1:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      MDU_OP_MULT, MDU_OP_MULTU, MDU_OP_DIV, MDU_OP_DIVU: ok = 1'b1;
`ifdef MDU_MADD_EN
      MDU_OP_MADD, MDU_OP_MADDU, MDU_OP_MSUB, MDU_OP_MSUBU: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Stateless arithmetic for the multiply/divide unit. Works on the operands
// latched at launch and the current HI/LO (accumulator for MADD/MSUB).
// res_valid=0 means HI/LO must be left untouched (divide by zero).
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_DEF_WIDTH
) (
  input  logic [MDU_OP_W-1:0] op,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [WIDTH-1:0]    hi,
  input  logic [WIDTH-1:0]    lo,
  output logic [WIDTH-1:0]    res_hi,
  output logic [WIDTH-1:0]    res_lo,
  output logic                res_valid
);

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic [2*WIDTH-1:0] prod_sel;
  logic [2*WIDTH-1:0] acc;
  logic               div_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   mag_q;
  logic [WIDTH-1:0]   mag_r;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic               b_zero;

  // Products, accumulate and a single magnitude divider shared by DIV/DIVU.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    res_hi    = hi;
    res_lo    = lo;
    res_valid = 1'b1;

    // Sign-extending to 2*WIDTH makes the modular product equal the signed product.
    prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    prod_sel = ((op == MDU_OP_MADDU) || (op == MDU_OP_MSUBU)) ? prod_u : prod_s;
    acc = {hi, lo};

    // Signed division via magnitudes: quotient truncates toward zero and the
    // remainder takes the dividend's sign. Most-negative / -1 falls out as a wrap.
    div_signed = (op == MDU_OP_DIV);
    a_neg  = div_signed & a[WIDTH-1];
    b_neg  = div_signed & b[WIDTH-1];
    mag_a  = a_neg ? (~a + 1'b1) : a;
    mag_b  = b_neg ? (~b + 1'b1) : b;
    b_zero = (b == '0);
    // Substitute 1 for a zero divisor so the divider never produces X; the result is discarded.
    mag_q  = mag_a / (b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b);
    mag_r  = mag_a % (b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b);
    quo    = (a_neg ^ b_neg) ? (~mag_q + 1'b1) : mag_q;
    rem    = a_neg ? (~mag_r + 1'b1) : mag_r;

    case (op)
      MDU_OP_MULT:  {res_hi, res_lo} = prod_s;
      MDU_OP_MULTU: {res_hi, res_lo} = prod_u;
      MDU_OP_DIV, MDU_OP_DIVU: begin
        res_hi    = rem;
        res_lo    = quo;
        res_valid = ~b_zero;
      end
      MDU_OP_MADD, MDU_OP_MADDU: {res_hi, res_lo} = acc + prod_sel;
      MDU_OP_MSUB, MDU_OP_MSUBU: {res_hi, res_lo} = acc - prod_sel;
      default: res_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Owns the launch/countdown FSM, the latched operands and HI/LO; the
// arithmetic itself lives in mdu_arith. HI/LO commit on the edge that
// drops busy. Optional feature macro: MDU_MADD_EN.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH       = MDU_DEF_WIDTH,
  parameter int MULT_CYCLES = MDU_DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DEF_DIV_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [MDU_OP_W-1:0] md_op,
  input  logic                we,
  input  logic [WIDTH-1:0]    src_a,
  input  logic [WIDTH-1:0]    src_b,
  output logic                busy,
  output logic [WIDTH-1:0]    hi,
  output logic [WIDTH-1:0]    lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MDU_OP_W-1:0] op_q, op_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0]    lo_q, lo_d;

  logic                launch;
  logic                mt_write;
  logic [WIDTH-1:0]    res_hi;
  logic [WIDTH-1:0]    res_lo;
  logic                res_valid;

  mdu_arith #(
    .WIDTH (WIDTH)
  ) u_arith (
    .op        (op_q),
    .a         (a_q),
    .b         (b_q),
    .hi        (hi_q),
    .lo        (lo_q),
    .res_hi    (res_hi),
    .res_lo    (res_lo),
    .res_valid (res_valid)
  );

  // Next-state logic: launch, MTHI/MTLO writes, countdown and result commit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    launch   = start && (state_q == ST_IDLE) && mdu_launchable(md_op);
    // A simultaneous start always suppresses the write, even if that start is itself ignored.
    mt_write = we && !start && (state_q == ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d = ST_BUSY;
          cnt_d   = mdu_is_div(md_op) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
          op_d    = md_op;
          a_d     = src_a;
          b_d     = src_b;
        end else if (mt_write) begin
          if (md_op == MDU_OP_MTHI) hi_d = src_a;
          if (md_op == MDU_OP_MTLO) lo_d = src_a;
        end
      end
      ST_BUSY: begin
        // HI/LO cannot change while busy, so the arith unit still sees the launch-time accumulator.
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          if (res_valid) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset discards any in-flight operation immediately.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MDU_OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == ST_BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
